// File: rtl/fixed_to_dec_tx_pkg.sv
// Shared types and constants for the fixed-point to decimal transmitter.
// Character codes and FSM state encoding live here.
package e_calc_pkg;
    localparam int WORD_W = 16;

    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_QMARK = 8'h3F;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        INT,
        DOT,
        MUL,
        EMIT,
        CR,
        LF,
        FIN
    } tx_state_t;
endpackage

// File: rtl/fixed_to_dec_tx_mul10_word.sv
// One 16-bit word times ten plus a decimal carry, carry out in the top nibble.
// Purely combinational; the transmitter reuses one instance per MUL cycle.
module mul10_word
    import e_calc_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [3:0]        carry_in,
    output logic [WORD_W-1:0] word_out,
    output logic [3:0]        carry_out
);
    logic [19:0] w_ext;
    logic [19:0] p;

    assign w_ext = {4'b0000, word};
    assign p     = (w_ext << 3) + (w_ext << 1) + {16'h0000, carry_in};
    assign word_out  = p[15:0];
    assign carry_out = p[19:16];
endmodule

// File: rtl/fixed_to_dec_tx.sv
// Streams a multiword fixed-point value as ASCII decimal over valid/ready.
// Define FIXED_TO_DEC_TX_CRLF_EN to append CR LF after the last digit.
module fixed_to_dec_tx
    import e_calc_pkg::*;
#(
    parameter int WORDS      = 32,
    parameter int NUM_DIGITS = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] fixed_data [WORDS],
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char
);
    localparam int KW = (WORDS > 2) ? $clog2(WORDS) : 1;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    tx_state_t         state;
    logic [WORD_W-1:0] fbuf [WORDS];
    logic [KW-1:0]     k;
    logic [3:0]        carry;
    logic [CW-1:0]     cnt;
    logic [WORD_W-1:0] mw;
    logic [3:0]        mc;
    logic              xfer;

    assign xfer = out_valid & out_ready;

    mul10_word u_mul (
        .word     (fbuf[k]),
        .carry_in (carry),
        .word_out (mw),
        .carry_out(mc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            k         <= '0;
            carry     <= '0;
            cnt       <= '0;
            for (int i = 0; i < WORDS; i++) fbuf[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < WORDS; i++) fbuf[i] <= fixed_data[i];
                        busy      <= 1'b1;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        // Integer part above 9 cannot be one digit
                        if (fixed_data[WORDS-1] <= 16'd9)
                            out_char <= ASC_ZERO + fixed_data[WORDS-1][7:0];
                        else
                            out_char <= ASC_QMARK;
                        state <= INT;
                    end
                end
                INT: begin
                    if (xfer) begin
                        out_char <= ASC_DOT;
                        state    <= DOT;
                    end
                end
                DOT: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        k         <= '0;
                        carry     <= '0;
                        state     <= MUL;
                    end
                end
                MUL: begin
                    fbuf[k] <= mw;
                    carry   <= mc;
                    if (k == KW'(WORDS - 2)) begin
                        out_valid <= 1'b1;
                        out_char  <= ASC_ZERO + {4'h0, mc};
                        state     <= EMIT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(NUM_DIGITS - 1)) begin
`ifdef FIXED_TO_DEC_TX_CRLF_EN
                            out_char <= ASC_CR;
                            state    <= CR;
`else
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= FIN;
`endif
                        end else begin
                            out_valid <= 1'b0;
                            k         <= '0;
                            carry     <= '0;
                            state     <= MUL;
                        end
                    end
                end
`ifdef FIXED_TO_DEC_TX_CRLF_EN
                CR: begin
                    if (xfer) begin
                        out_char <= ASC_LF;
                        state    <= LF;
                    end
                end
                LF: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
`endif
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_to_dec_tx.sv
// Scoreboard bench for fixed_to_dec_tx at WORDS=4, NUM_DIGITS=6.
// Expected characters are queued by stimulus and popped by a monitor.
module tb_fixed_to_dec_tx;
    import e_calc_pkg::*;

    localparam int WORDS      = 4;
    localparam int NUM_DIGITS = 6;
`ifdef FIXED_TO_DEC_TX_CRLF_EN
    localparam int NCHARS = NUM_DIGITS + 4;
`else
    localparam int NCHARS = NUM_DIGITS + 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [WORD_W-1:0] fixed_data [WORDS];
    logic              busy;
    logic              done;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [7:0]        out_char;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_xfer = 0;
    int n_done = 0;
    logic [7:0] expq [$];
    int xq [$];

    fixed_to_dec_tx #(.WORDS(WORDS), .NUM_DIGITS(NUM_DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .fixed_data(fixed_data),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n && out_valid && out_ready) begin
            n_xfer++;
            xq.push_back(cyc);
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_char: got=%0h expected=none", out_char);
            end else begin
                check("char", int'(out_char), int'(expq.pop_front()));
            end
        end
        if (done) n_done++;
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
`ifdef FIXED_TO_DEC_TX_CRLF_EN
        expq.push_back(8'h0D);
        expq.push_back(8'h0A);
`endif
    endtask

    task automatic load(input logic [15:0] w3, input logic [15:0] w2,
                        input logic [15:0] w1, input logic [15:0] w0);
        fixed_data[3] = w3;
        fixed_data[2] = w2;
        fixed_data[1] = w1;
        fixed_data[0] = w0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got=0 expected=1");
        end else begin
            check("busy_at_done", int'(busy), 1);
            @(negedge clk);
            check("busy_after", int'(busy), 0);
            check("done_one_cycle", int'(done), 0);
        end
    endtask

    task automatic finish_run(input string name, input int done0);
        wait_done();
        repeat (3) @(negedge clk);
        check({name, "_count"}, n_xfer, NCHARS);
        check({name, "_left"}, expq.size(), 0);
        check({name, "_dones"}, n_done - done0, 1);
    endtask

    initial begin
        int d0;
        bit got;
        load(16'h0002, 16'hB7E1, 16'h5162, 16'h8AED);
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_char", int'(out_char), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // e with backpressure on the first character
        n_xfer = 0; d0 = n_done;
        push_str("2.718281");
        out_ready = 1'b0;
        pulse_start();
        @(negedge clk);
        check("busy_after_start", int'(busy), 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_char", int'(out_char), 8'h32);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("dot_after_ready", int'(out_char), 8'h2E);
        finish_run("e", d0);

        // Exact half, also measure character spacing
        load(16'h0000, 16'h8000, 16'h0000, 16'h0000);
        n_xfer = 0; d0 = n_done; xq.delete();
        push_str("0.500000");
        pulse_start();
        finish_run("half", d0);
        for (int i = 2; i < 8; i++) check("spacing", xq[i] - xq[i-1], 4);

        // Integer overflow with a start pulse mid-stream
        load(16'h000A, 16'hB7E1, 16'h5162, 16'h8AED);
        n_xfer = 0; d0 = n_done;
        push_str("?.718281");
        pulse_start();
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_run("ovf", d0);

        // Reset during the third digit's multiply
        load(16'h0002, 16'hB7E1, 16'h5162, 16'h8AED);
        n_xfer = 0; d0 = n_done;
        push_str("2.718281");
        pulse_start();
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (n_xfer >= 4) got = 1;
        end
        check("reach_digit3", int'(got), 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        expq.delete();
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_nodone", n_done - d0, 0);

        n_xfer = 0; d0 = n_done;
        push_str("2.718281");
        pulse_start();
        finish_run("after_rst", d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
